fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised forwarding + load-use hazard unit for the pipelined core. Internally tracks
//  in-flight register writes over FWD_DEPTH post-EX stages, so the pipeline feeds it only the EX
//  instruction. Outputs per-operand bypass selects (youngest producer wins), a load-use stall
//  and a saturating stall counter. Sits beside the ID/EX register and drives the EX operand muxes.
// PARAMETERS
//  REG_AW     4  register address width
//  NUM_SRC    2  source operands per instruction (rs, rt, ...)
//  FWD_DEPTH  2  tracked stages after EX (slot1=EX/MEM, slot2=MEM/WB, ...)
//  LOAD_STAGE 2  first slot where load data is forwardable; valid range 1..FWD_DEPTH
//  CNT_W      16 stall counter width
// PORTS
//  clk         in  1                clock, rising edge
//  rst_n       in  1                synchronous reset, active-low
//  ex_valid    in  1                EX holds a real instruction
//  ex_rs       in  NUM_SRC*REG_AW   source addresses; operand s = bits [s*REG_AW +: REG_AW]
//  ex_rd       in  REG_AW           destination of EX instruction
//  ex_rw       in  1                EX instruction writes ex_rd
//  ex_is_load  in  1                EX instruction is a load
//  flush       in  1                kill EX instruction (branch redirect)
//  fwd_sel     out NUM_SRC*SELW     per operand: 0 = regfile, k = bypass from slot k
//  stall       out 1                hold PC/IF/ID/EX this cycle
//  stall_cnt   out CNT_W            total cycles stalled, saturating
// BEHAVIOUR
//  - SELW = clog2(FWD_DEPTH+1). Slot entry = {valid, rw, is_load, rd}.
//  - Reset (rst_n=0 at clk edge): all slots valid=0, stall_cnt=0; so fwd_sel=0 and stall=0 on the
//    first cycle after reset. Reset mid-stall drops the stall; the held instruction is re-sent by
//    the pipeline.
//  - Match for operand s at slot k: slot valid & rw & rd==rs[s] & ex_valid.
//  - fwd_sel[s] = smallest matching k (youngest); 0 if none. Combinational, zero latency.
//  - stall = ex_valid & !flush & any operand whose youngest match is a load in slot k<LOAD_STAGE.
//    Older non-load matches never stall; a younger non-load match masks an older load.
//  - Per clock: slot[k] <= slot[k-1] for k>=2 (always; older instructions keep moving).
//    slot[1] <= EX entry if ex_valid & !flush & !stall, else bubble (valid=0).
//  - fwd_sel is don't-care while stall=1. Bench checks fwd_sel only when stall=0.
//  - stall_cnt increments on each stall=1 cycle; holds at 2^CNT_W-1.
//  - Simultaneous flush & hazard: flush wins; stall=0, no count, bubble into slot1.
//  - LOAD_STAGE=1: loads never stall.
//  - ex_rw=0 or ex_valid=0: EX entry produces no later matches.
// CONFIGURATION
//  ZERO_REG_EN defined: address 0 is hardwired zero. Slots with rd==0 never match; operands
//    with rs==0 always get fwd_sel=0 and never stall.
//  Not defined: address 0 is an ordinary register and is forwarded like any other.
// STRUCTURE
//  Package fwd_pkg: slot_t struct {valid,rw,is_load,rd}; function sel_w(depth) returning clog2;
//    sel encoding constant SEL_RF=0.
//  Sub-module fwd_match: one operand address vs. slot array -> youngest index + load_hazard bit.
//    Instantiated NUM_SRC times in a generate loop. Top holds the slot shift register, stall OR
//    and counter.
// TESTING (default params unless stated)
//  1. add r3 in EX, then sub r5 reading rs=r3 -> fwd_sel[0]=1. One cycle later, an instruction
//     reading r3 -> fwd_sel=2. Next cycle -> 0.
//  2. r3 written by both slot1 and slot2, operand rt=r3 -> fwd_sel[1]=1 (youngest).
//  3. lw r4 in EX, next instr reads r4 -> stall=1 for exactly 1 cycle and slot1 becomes a bubble.
//     Following cycle -> stall=0, fwd_sel=2. stall_cnt 0->1.
//  4. lw r4 followed by a reading instruction with flush=1 on that cycle -> stall=0, stall_cnt
//     unchanged, slot1 bubble.
//  5. With ZERO_REG_EN, write r0 then read r0 -> fwd_sel=0. Without the macro -> fwd_sel=1.
//  6. CNT_W=2, hazard forced for 5 cycles -> stall_cnt 1,2,3,3,3. Then rst_n=0 for one edge
//     -> stall_cnt=0 and stall=0.

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_pkg: slot entry type, select-width helper and select encoding for the forwarding unit
package fwd_pkg;
   localparam int MAX_AW = 8;
   localparam int SEL_RF = 0;
   typedef struct packed {
      logic              valid;
      logic              rw;
      logic              is_load;
      logic [MAX_AW-1:0] rd;
   } slot_t;
   function automatic int sel_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/fwd_match.sv
// fwd_match: youngest in-flight producer of one operand plus its load-use hazard (ZERO_REG_EN: r0 never matches)
module fwd_match
   import fwd_pkg::*;
#(
   parameter int REG_AW     = 4,
   parameter int FWD_DEPTH  = 2,
   parameter int LOAD_STAGE = 2,
   parameter int SELW       = sel_w(FWD_DEPTH)
) (
   input  logic                i_ex_valid,
   input  logic [REG_AW-1:0]   i_rs,
   input  slot_t [FWD_DEPTH:1] i_slots,
   output logic [SELW-1:0]     o_sel,
   output logic                o_load_hazard
);
`ifdef ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif
   logic w_rs_zero;
   assign w_rs_zero = ZERO_REG & (i_rs == '0);
   // scan oldest to youngest so the youngest matching slot has the final say
   always_comb begin
      o_sel = SELW'(SEL_RF);
      o_load_hazard = 1'b0;
      for (int k = FWD_DEPTH; k >= 1; k--)
         if (i_ex_valid & i_slots[k].valid & i_slots[k].rw & ~w_rs_zero & (i_slots[k].rd == MAX_AW'(i_rs))) begin
            o_sel = SELW'(k);
            o_load_hazard = i_slots[k].is_load & (k < LOAD_STAGE);
         end
   end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand bypass selects, load-use stall and saturating stall counter (ZERO_REG_EN: r0 hardwired zero)
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int  REG_AW     = 4,
   parameter int  NUM_SRC    = 2,
   parameter int  FWD_DEPTH  = 2,
   parameter int  LOAD_STAGE = 2,
   parameter int  CNT_W      = 16,
   localparam int SELW       = sel_w(FWD_DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_ex_valid,
   input  logic [NUM_SRC*REG_AW-1:0] i_ex_rs,
   input  logic [REG_AW-1:0]         i_ex_rd,
   input  logic                      i_ex_rw,
   input  logic                      i_ex_is_load,
   input  logic                      i_flush,
   output logic [NUM_SRC*SELW-1:0]   o_fwd_sel,
   output logic                      o_stall,
   output logic [CNT_W-1:0]          o_stall_cnt
);
   slot_t [FWD_DEPTH:1] r_slots;
   logic [CNT_W-1:0]    r_stall_cnt;
   logic [NUM_SRC-1:0]  w_haz;
   logic                w_issue;
   slot_t               w_entry;
   genvar s;
   for (s = 0; s < NUM_SRC; s++) begin : g_src
      fwd_match #(
         .REG_AW    (REG_AW),
         .FWD_DEPTH (FWD_DEPTH),
         .LOAD_STAGE(LOAD_STAGE),
         .SELW      (SELW)
      ) u_match (
         .i_ex_valid   (i_ex_valid),
         .i_rs         (i_ex_rs[s*REG_AW +: REG_AW]),
         .i_slots      (r_slots),
         .o_sel        (o_fwd_sel[s*SELW +: SELW]),
         .o_load_hazard(w_haz[s])
      );
   end
   assign o_stall     = i_ex_valid & ~i_flush & (|w_haz);
   assign w_issue     = i_ex_valid & ~i_flush & ~o_stall;
   assign w_entry     = '{valid: w_issue, rw: i_ex_rw, is_load: i_ex_is_load, rd: MAX_AW'(i_ex_rd)};
   assign o_stall_cnt = r_stall_cnt;
   // older slots always advance; slot1 takes the EX instruction only when it actually leaves EX
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_slots <= '0;
      end else begin
         r_slots[1] <= w_entry;
         for (int k = 2; k <= FWD_DEPTH; k++)
            r_slots[k] <= r_slots[k-1];
      end
   end
   // count stalled cycles, sticking at the all-ones value
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_stall_cnt <= '0;
      else if (o_stall && r_stall_cnt != '1)
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed vectors with an instruction-history model of the forwarding rules
module tb_fwd_hazard_unit;
   localparam int AW = 4;
   localparam int D  = 2;
   localparam int LS = 2;
   localparam int SW = 2;
`ifdef ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_rw = 1'b0;
   logic        ex_ld = 1'b0;
   logic        flush = 1'b0;
   logic [7:0]  ex_rs = '0;
   logic [3:0]  ex_rd = '0;
   logic [3:0]  fwd_sel, fwd_sel2;
   logic        stall, stall2;
   logic [15:0] cnt;
   logic [1:0]  cnt2;
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit dut (
      .clk(clk), .rst_n(rst_n), .i_ex_valid(ex_valid), .i_ex_rs(ex_rs), .i_ex_rd(ex_rd),
      .i_ex_rw(ex_rw), .i_ex_is_load(ex_ld), .i_flush(flush),
      .o_fwd_sel(fwd_sel), .o_stall(stall), .o_stall_cnt(cnt)
   );
   fwd_hazard_unit #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .i_ex_valid(ex_valid), .i_ex_rs(ex_rs), .i_ex_rd(ex_rd),
      .i_ex_rw(ex_rw), .i_ex_is_load(ex_ld), .i_flush(flush),
      .o_fwd_sel(fwd_sel2), .o_stall(stall2), .o_stall_cnt(cnt2)
   );

   typedef struct {bit v; bit rw; bit ld; int rd;} ent_t;
   ent_t hist[$];
   int   m_cnt = 0;
   bit   m_init = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int m_sel(input int s);
      int rs;
      rs = int'(ex_rs[s*AW +: AW]);
      for (int k = 1; k <= D; k++)
         if (ex_valid && hist[k-1].v && hist[k-1].rw && hist[k-1].rd == rs && !(ZR && rs == 0))
            return k;
      return 0;
   endfunction

   function automatic bit m_stall();
      int k;
      if (!ex_valid || flush) return 1'b0;
      for (int s = 0; s < 2; s++) begin
         k = m_sel(s);
         if (k > 0 && hist[k-1].ld && k < LS) return 1'b1;
      end
      return 1'b0;
   endfunction

   // history of what left EX each cycle, newest first
   always @(posedge clk) begin
      bit st;
      if (!rst_n) begin
         hist = {};
         repeat (D) hist.push_back('{1'b0, 1'b0, 1'b0, 0});
         m_cnt = 0;
         m_init = 1'b1;
      end else begin
         st = m_stall();
         if (st) m_cnt++;
         hist.push_front('{ex_valid && !flush && !st, ex_rw, ex_ld, int'(ex_rd)});
         void'(hist.pop_back());
      end
   end

   always @(negedge clk) begin
      bit st;
      if (m_init) begin
         st = m_stall();
         chk("stall", stall, int'(st));
         chk("stall_w2", stall2, int'(st));
         if (!st)
            for (int s = 0; s < 2; s++) begin
               chk("fwd_sel", fwd_sel[s*SW +: SW], m_sel(s));
               chk("fwd_sel_w2", fwd_sel2[s*SW +: SW], m_sel(s));
            end
         chk("stall_cnt", cnt, m_cnt > 65535 ? 65535 : m_cnt);
         chk("stall_cnt_w2", cnt2, m_cnt > 3 ? 3 : m_cnt);
      end
   end

   task automatic drive(input bit v, input int r0, input int r1, input int rd, input bit rw, input bit ld, input bit fl);
      ex_valid = v;
      ex_rs = {4'(r1), 4'(r0)};
      ex_rd = 4'(rd);
      ex_rw = rw;
      ex_ld = ld;
      flush = fl;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp2[5];
      exp2 = '{1, 2, 3, 3, 3};
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) cyc();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_stall", stall, 0);
      chk("rst_sel", fwd_sel, 0);
      chk("rst_cnt", cnt, 0);
      cyc();
      drive(1, 1, 2, 3, 1, 0, 0); cyc();
      drive(1, 3, 9, 5, 1, 0, 0); @(negedge clk); chk("t1_slot1", fwd_sel[1:0], 1); cyc();
      drive(1, 3, 9, 6, 1, 0, 0); @(negedge clk); chk("t1_slot2", fwd_sel[1:0], 2); cyc();
      drive(1, 3, 9, 7, 1, 0, 0); @(negedge clk); chk("t1_gone", fwd_sel[1:0], 0); cyc();
      drive(1, 9, 9, 3, 1, 0, 0); cyc(); cyc();
      drive(1, 9, 3, 8, 1, 0, 0); @(negedge clk); chk("t2_youngest", fwd_sel[3:2], 1); cyc();
      drive(1, 9, 9, 4, 1, 1, 0); cyc();
      drive(1, 4, 9, 10, 1, 0, 0); @(negedge clk);
      chk("t3_stall", stall, 1); chk("t3_cnt_before", cnt, 0); cyc();
      @(negedge clk);
      chk("t3_release", stall, 0); chk("t3_sel", fwd_sel[1:0], 2); chk("t3_cnt", cnt, 1); cyc();
      drive(1, 9, 9, 4, 1, 1, 0); cyc();
      drive(1, 4, 9, 11, 1, 0, 1); @(negedge clk); chk("t4_flush_stall", stall, 0); cyc();
      drive(1, 4, 9, 12, 1, 0, 0); @(negedge clk);
      chk("t4_bubble_sel", fwd_sel[1:0], 2); chk("t4_stall", stall, 0); chk("t4_cnt", cnt, 1); cyc();
      drive(1, 9, 9, 0, 1, 0, 0); cyc();
      drive(1, 0, 9, 13, 1, 0, 0); @(negedge clk); chk("t5_r0", fwd_sel[1:0], ZR ? 0 : 1); cyc();
      drive(1, 9, 9, 4, 1, 1, 0); cyc();
      drive(1, 9, 9, 4, 1, 0, 0); cyc();
      drive(1, 4, 9, 14, 1, 0, 0); @(negedge clk);
      chk("mask_stall", stall, 0); chk("mask_sel", fwd_sel[1:0], 1); cyc();
      drive(0, 9, 9, 15, 1, 0, 0); cyc();
      drive(1, 15, 9, 1, 1, 0, 0); @(negedge clk); chk("invalid_ex", fwd_sel[1:0], 0); cyc();
      drive(1, 9, 9, 2, 0, 0, 0); cyc();
      drive(1, 2, 9, 1, 1, 0, 0); @(negedge clk); chk("no_write", fwd_sel[1:0], 0); cyc();
      rst_n = 1'b0; drive(0, 0, 0, 0, 0, 0, 0); cyc(); rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1, 9, 9, 4, 1, 1, 0); cyc();
         drive(1, 4, 9, 5, 1, 0, 0); cyc();
         @(negedge clk); chk("t6_cnt2", cnt2, exp2[i]);
      end
      drive(1, 9, 9, 4, 1, 1, 0); cyc();
      drive(1, 4, 9, 5, 1, 0, 0); rst_n = 1'b0;
      @(negedge clk); chk("t6_pre_rst_stall", stall2, 1); cyc();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_rst_cnt2", cnt2, 0); chk("t6_rst_cnt", cnt, 0); chk("t6_rst_stall", stall2, 0);
      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
